regfile_pending_encoder: RTL
============================

REGFILE_PENDING_ENCODER -- requirements
Module: regfile_pending_encoder

Interface
REQ-001 Parameter: none; all widths fixed (32 registers, 5-bit index).
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 ctrl_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 set_en  input  1  qualifies set_mask this cycle.
REQ-005 set_mask  input  32  multi-hot register flags to mark pending.
REQ-006 out_ready  input  1  consumer accepts out_sel this cycle.
REQ-007 out_valid  output  1  out_sel holds a valid register index.
REQ-008 out_sel  output  5  encoded register index, registered.
REQ-009 pending_cnt  output  6  population count of pending vector, registered.

Function
REQ-010 Block SHALL hold a 32-bit pending vector; bit i set means index i awaits emission.
REQ-011 At each edge with set_en=1, pending SHALL OR in set_mask[31:1]; set_mask[0] SHALL always be ignored (register 0 is hardwired zero).
REQ-012 Two states: IDLE (out_valid=0), HOLD (out_valid=1).
REQ-013 IDLE: if pending (pre-set value) non-zero, at the edge SHALL load out_sel with selected index, clear that bit, enter HOLD; else stay IDLE.
REQ-014 HOLD with out_ready=0: out_sel, out_valid SHALL remain stable.
REQ-015 HOLD with out_ready=1: if pending non-zero, SHALL load next selected index and clear its bit in the same edge (one index per cycle, no bubble); else go IDLE.
REQ-016 Selection (base): lowest set index in pending.
REQ-017 Set and clear of the same bit at one edge: set SHALL win (bit stays pending, re-emitted later).
REQ-018 Setting the index currently held in out_sel SHALL mark it pending again; no merge.
REQ-019 Latency: set_mask sampled at edge k with empty pending and IDLE -> out_valid=1 after edge k+1.
REQ-020 pending_cnt SHALL equal popcount of pending after each edge (excludes held index); range 0-31.
REQ-021 set_en=1 with set_mask all-ones (bit 0 ignored) SHALL yield pending_cnt=31, no overflow.

Reset
REQ-022 ctrl_reset_n=0 SHALL immediately force pending=0, state IDLE, out_valid=0, out_sel=0, pending_cnt=0, and any round-robin pointer=0.
REQ-023 Reset mid-HOLD SHALL discard held index and all pending bits; no emission after release until new set.
REQ-024 First edge after deassertion SHALL operate normally.

Configuration
REQ-025 Macro REGFILE_PENDING_RR_EN defined: selection SHALL be round-robin -- lowest set index strictly greater than last emitted index, wrapping to 1; pointer updates on each load.
REQ-026 Macro undefined: fixed lowest-index priority per REQ-016; no pointer register present.

Verification
REQ-027 Reset, then set_en=1, set_mask=0x0000_0001 -> out_valid stays 0, pending_cnt=0.
REQ-028 set_mask=0x8000_0012, out_ready=1 held -> out_sel 1, 4, 31 on consecutive cycles, then out_valid=0; pending_cnt 2,1,0,0.
REQ-029 set_mask=0x0000_0006, out_ready=0 for 5 cycles -> out_sel=1 stable 5 cycles, pending_cnt=1; raise out_ready -> out_sel=2 next cycle.
REQ-030 While holding index 3 with out_ready=1, set_mask=0x0000_0008 same cycle -> index 3 emitted again on later cycle.
REQ-031 ctrl_reset_n pulsed low between edges during HOLD with pending_cnt=4 -> out_valid=0, pending_cnt=0 immediately, no later output.
REQ-032 With REGFILE_PENDING_RR_EN: emit 5, then set_mask=0x0000_0042 -> next out_sel=6, then 1.

Source files
------------

// File: rtl/regfile_pending_encoder.sv
// Pending-register encoder: collects multi-hot register flags and emits one index per cycle.
// Define REGFILE_PENDING_RR_EN for round-robin selection instead of lowest-index priority.
module regfile_pending_encoder (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        set_en,
  input  logic [31:0] set_mask,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_sel,
  output logic [5:0]  pending_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state;
  logic [31:0] pending;
  logic [31:0] pendingNext;
  logic [31:0] clearMask;
  logic [31:0] setBits;
  logic [4:0]  selIdx;
  logic        selFound;
  logic        loadSel;

  function automatic logic [4:0] lowestIdx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic logic [5:0] popCount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

`ifdef REGFILE_PENDING_RR_EN
  logic [4:0]  lastIdx;
  logic [31:0] upperPending;

  // Prefer indices above the last emitted one; bit 0 is never pending, so wrap lands on 1.
  always_comb begin
    upperPending = '0;
    for (int i = 0; i < 32; i++) begin
      if (5'(i) > lastIdx) upperPending[i] = pending[i];
    end
    selFound = |pending;
    selIdx   = (|upperPending) ? lowestIdx(upperPending) : lowestIdx(pending);
  end
`else
  always_comb begin
    selFound = |pending;
    selIdx   = lowestIdx(pending);
  end
`endif

  // A new set of the bit being cleared keeps it pending.
  always_comb begin
    loadSel     = selFound && ((state == IDLE) || out_ready);
    clearMask   = loadSel ? (32'd1 << selIdx) : '0;
    setBits     = set_en ? (set_mask & 32'hFFFF_FFFE) : '0;
    pendingNext = (pending & ~clearMask) | setBits;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state       <= IDLE;
      pending     <= '0;
      out_valid   <= 1'b0;
      out_sel     <= '0;
      pending_cnt <= '0;
    end else begin
      pending     <= pendingNext;
      pending_cnt <= popCount(pendingNext);
      case (state)
        IDLE: begin
          if (loadSel) begin
            out_sel   <= selIdx;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (loadSel) begin
              out_sel <= selIdx;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef REGFILE_PENDING_RR_EN
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      lastIdx <= '0;
    end else if (loadSel) begin
      lastIdx <= selIdx;
    end
  end
`endif

endmodule
